// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer between the AXI write/read request ports and a single I2C master engine.
// Optional completion timeout is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
    parameter int AD_W           = 16,
    parameter int RD_W           = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic            aclk_i,
    input  logic            areset_i,
    input  logic            wr_req_i,
    input  logic [AD_W-1:0] wr_addr_data_i,
    output logic            wr_done_o,
    output logic            wr_acked_o,
    input  logic            rd_req_i,
    input  logic [AD_W-1:0] rd_addr_i,
    output logic [RD_W-1:0] rd_data_o,
    output logic            rd_data_valid_o,
    input  logic            rd_data_ack_i,
    output logic            cmd_valid_o,
    input  logic            cmd_ready_i,
    output logic            cmd_rw_o,
    output logic [AD_W-1:0] cmd_addr_data_o,
    input  logic            i2c_done_i,
    input  logic            i2c_ack_i,
    input  logic [RD_W-1:0] i2c_rdata_i,
    output logic            pending_transaction_wr_o,
    output logic            pending_transaction_rd_o,
    output logic            busy_o,
    output logic            timeout_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RD_HOLD} state_t;

    // The timeout counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65536");
    end

    state_t          state_q;
    logic            last_rd_q;
    logic            cmd_valid_q;
    logic            cmd_rw_q;
    logic [AD_W-1:0] cmd_ad_q;
    logic [RD_W-1:0] rd_data_q;
    logic            rd_valid_q;
    logic            wr_done_q;
    logic            wr_acked_q;
    logic            grant_rd_d;
    logic            tmo_expired;
    logic            wr_completing;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;
    logic        tmo_err_q;
    assign tmo_expired   = (tmo_cnt_q == TMO_LAST);
    assign timeout_err_o = tmo_err_q;
`else
    assign tmo_expired   = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // On a tie, serve the direction that did not win last time.
    assign grant_rd_d = rd_req_i & (~wr_req_i | ~last_rd_q);

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q     <= IDLE;
            last_rd_q   <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_rw_q    <= 1'b0;
            cmd_ad_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            wr_acked_q  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_req_i | rd_req_i) begin
                        state_q     <= ISSUE;
                        cmd_valid_q <= 1'b1;
                        cmd_rw_q    <= grant_rd_d;
                        cmd_ad_q    <= grant_rd_d ? rd_addr_i : wr_addr_data_i;
                        last_rd_q   <= grant_rd_d;
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        state_q     <= WAIT_DONE;
                        cmd_valid_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    // A real completion in the expiry cycle takes priority over the abort.
                    if (i2c_done_i | tmo_expired) begin
                        if (cmd_rw_q) begin
                            rd_data_q  <= i2c_done_i ? i2c_rdata_i : '0;
                            rd_valid_q <= 1'b1;
                            state_q    <= RD_HOLD;
                        end else begin
                            wr_done_q  <= 1'b1;
                            wr_acked_q <= i2c_done_i & i2c_ack_i;
                            state_q    <= IDLE;
                        end
`ifdef I2C_ARB_TIMEOUT_EN
                        if (!i2c_done_i) tmo_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
                    end
                end
                RD_HOLD: begin
                    if (rd_data_ack_i) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A write stops being pending from its completing cycle through the WR_DONE pulse.
    assign wr_completing = ((state_q == WAIT_DONE) & ~cmd_rw_q & (i2c_done_i | tmo_expired))
                         | wr_done_q;

    assign pending_transaction_wr_o = ~areset_i & wr_req_i & ~wr_completing;
    assign pending_transaction_rd_o = ~areset_i & (rd_req_i | ((state_q != IDLE) & cmd_rw_q));

    assign busy_o          = (state_q != IDLE);
    assign cmd_valid_o     = cmd_valid_q;
    assign cmd_rw_o        = cmd_rw_q;
    assign cmd_addr_data_o = cmd_ad_q;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_valid_q;
    assign wr_done_o       = wr_done_q;
    assign wr_acked_o      = wr_acked_q;

endmodule
